// File: rtl/cache_line_param.sv
// One way of a cache set: data words, tag, valid and dirty state, tag compare,
// byte-enabled write hits, and burst refill / write-back sequencers.
module cache_line_param #(
    parameter int WORDS  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 25,
    localparam int OFF_W = $clog2(WORDS),
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TAG_W-1:0]  lookup_tag,
    input  logic [OFF_W-1:0]  rd_offset,
    output logic [DATA_W-1:0] rd_data,
    output logic              hit,
    input  logic              wr_en,
    input  logic [OFF_W-1:0]  wr_offset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              invalidate,
    input  logic              fill_start,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              wb_start,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [OFF_W-1:0]  wb_offset,
    output logic [DATA_W-1:0] wb_data,
    output logic [TAG_W-1:0]  tag_out,
    output logic              valid_out,
    output logic              dirty_out,
    output logic              busy,
    output logic              fill_done,
    output logic              wb_done,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_WB   = 2'd2
    } state_e;

    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);

    state_e             state_q;
    logic [OFF_W-1:0]   cnt_q;
    logic [TAG_W-1:0]   tag_q;
    logic               valid_q;
    logic               dirty_q;
    logic               fill_done_q;
    logic               wb_done_q;
    logic [DATA_W-1:0]  mem_q [WORDS];
    logic [DATA_W-1:0]  wr_word_d;

    // Byte merge of the write-hit data into the currently stored word.
    always_comb begin
        wr_word_d = mem_q[wr_offset];
        for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) begin
                wr_word_d[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    assign hit         = valid_q && (tag_q == lookup_tag) && (state_q == S_IDLE);
    assign rd_data     = mem_q[rd_offset];
    assign wb_valid    = (state_q == S_WB);
    assign wb_offset   = cnt_q;
    assign wb_data     = mem_q[cnt_q];
    assign tag_out     = tag_q;
    assign valid_out   = valid_q;
    assign dirty_out   = dirty_q;
    assign busy        = (state_q != S_IDLE);
    assign fill_done   = fill_done_q;
    assign wb_done     = wb_done_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
            dirty_q     <= 1'b0;
            fill_done_q <= 1'b0;
            wb_done_q   <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            fill_done_q <= 1'b0;
            wb_done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Write-back wins over refill; a dropped fill_start is re-issued later.
                    if (wb_start) begin
                        state_q <= S_WB;
                        cnt_q   <= '0;
                    end else if (fill_start) begin
                        state_q <= S_FILL;
                        cnt_q   <= '0;
                        tag_q   <= fill_tag;
                        valid_q <= 1'b0;
                        dirty_q <= 1'b0;
                    end else if (invalidate) begin
                        valid_q <= 1'b0;
                        dirty_q <= 1'b0;
                    end else if (wr_en && hit) begin
                        mem_q[wr_offset] <= wr_word_d;
                        dirty_q          <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (fill_valid) begin
                        mem_q[cnt_q] <= fill_data;
                        if (cnt_q == LAST) begin
                            state_q     <= S_IDLE;
                            valid_q     <= 1'b1;
                            dirty_q     <= 1'b0;
                            fill_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + OFF_W'(1);
                        end
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        if (cnt_q == LAST) begin
                            state_q   <= S_IDLE;
                            dirty_q   <= 1'b0;
                            wb_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + OFF_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
